load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TimeoutCycles, default 15: the maximum number of cycles spent in REQ plus WAIT before the access is aborted.
REQ-002 The block SHALL have parameter DPW, default 32 (from rv32i_pkg): the data and address width.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  MEM-stage access present; the core holds all req_* inputs stable while stall=1.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 req_addr  in  DPW  byte address (aluresultM).
REQ-010 req_wdata  in  DPW  store data, right-aligned (Rd2M).
REQ-011 stall  out  1  freezes the pipeline.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 load_data  out  DPW  extended load result.
REQ-014 misalign  out  1  pulse coincident with done: access rejected.
REQ-015 timeout  out  1  pulse coincident with done: memory did not respond in time.
REQ-016 mem_req  out  1  request to data memory.
REQ-017 mem_we  out  1  request is a write.
REQ-018 mem_addr  out  DPW  word-aligned address, req_addr with bits [1:0] forced to 0.
REQ-019 mem_wstrb  out  4  byte-lane write enables.
REQ-020 mem_wdata  out  DPW  lane-shifted store data.
REQ-021 mem_ready  in  1  memory accepts the request.
REQ-022 mem_rvalid  in  1  read data valid.
REQ-023 mem_rdata  in  DPW  read word.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, WAIT and DONE, with DONE lasting exactly one cycle and returning to IDLE.
REQ-025 stall SHALL be combinational: req_valid AND NOT done.
REQ-026 In IDLE with req_valid=1, the block SHALL check alignment: half is misaligned if addr[0]=1, word if addr[1:0]!=00, and size 11 is always misaligned.
REQ-027 On a misaligned access the block SHALL go to DONE with misalign=1, issue no memory request, and leave load_data unchanged.
REQ-028 On an aligned access the block SHALL register address, we, strobes and write data, then go to REQ.
REQ-029 Strobes: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
REQ-030 mem_wdata SHALL be req_wdata<<(8*addr[1:0]).
REQ-031 In REQ, mem_req=1 and all mem_* outputs SHALL stay stable until mem_ready=1.
REQ-032 A store handshake (mem_req AND mem_ready) SHALL go to DONE.
REQ-033 A load handshake SHALL go to WAIT, or directly to DONE if mem_rvalid=1 in the same cycle, capturing the data.
REQ-034 In WAIT, mem_req=0, and mem_rvalid=1 SHALL capture mem_rdata and go to DONE.
REQ-035 Load extraction: take the byte or half at lane addr[1:0], then zero- or sign-extend to DPW per req_unsigned; word is passed through unchanged.
REQ-036 load_data SHALL update only on the DONE of a successful load and hold otherwise.
REQ-037 A counter SHALL count cycles in REQ and WAIT; on reaching TimeoutCycles the block SHALL go to DONE with timeout=1, set load_data to 0, and drop mem_req.
REQ-038 The counter SHALL clear on entry to REQ.
REQ-039 In DONE, req_valid SHALL be ignored; a new request is sampled in IDLE on the next cycle.
REQ-040 mem_rvalid arriving in IDLE, REQ-before-handshake, or DONE SHALL be ignored.
REQ-041 Minimum latency with mem_ready=1: store done 2 cycles after req_valid rises; load with single-cycle rvalid done 3 cycles after.

Reset
REQ-042 While rst=1, the block SHALL hold state IDLE, counter 0, and drive done, misalign, timeout, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata and load_data to 0.
REQ-043 rst=1 during REQ or WAIT SHALL abort the access: mem_req=0 from the cycle after rst is sampled, and no done pulse is produced.

Verification
REQ-044 Store byte: addr=0x0000_0013, wdata=0x0000_00AB, mem_ready=1 -> mem_addr=0x10, wstrb=1000, mem_wdata=0xAB00_0000, done 2 cycles after request.
REQ-045 Signed half load: addr=0x22, mem_rdata=0x8001_7FFF with rvalid 1 cycle after handshake -> load_data=0xFFFF_8001; with req_unsigned=1 -> 0x0000_8001.
REQ-046 Misaligned word: addr=0x06 -> misalign=1 and done=1 on the same cycle, mem_req never asserted, load_data unchanged.
REQ-047 Backpressure: mem_ready=0 for 5 cycles -> mem_req and mem_* stable for 6 cycles, stall=1 throughout, done after handshake.
REQ-048 Timeout: load, mem_ready=1, rvalid never -> timeout=1 with done after 15 cycles in REQ/WAIT, load_data=0.
REQ-049 Reset in WAIT -> mem_req=0 and IDLE next cycle, no done; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit: alignment check, lane steering,
// memory handshake with response timeout, and load extraction/extension.
module load_store_unit #(
  parameter int TimeoutCycles = 15,
  parameter int DPW           = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_unsigned,
  input  logic [DPW-1:0] req_addr,
  input  logic [DPW-1:0] req_wdata,
  output logic           stall,
  output logic           done,
  output logic [DPW-1:0] load_data,
  output logic           misalign,
  output logic           timeout,
  output logic           mem_req,
  output logic           mem_we,
  output logic [DPW-1:0] mem_addr,
  output logic [3:0]     mem_wstrb,
  output logic [DPW-1:0] mem_wdata,
  input  logic           mem_ready,
  input  logic           mem_rvalid,
  input  logic [DPW-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int CW = $clog2(TimeoutCycles + 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DPW-1:0] addr_q, addr_d;
  logic           we_q, we_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic [DPW-1:0] wdata_q, wdata_d;
  logic [1:0]     off_q, off_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic           misalign_q, misalign_d;
  logic           timeout_q, timeout_d;
  logic [DPW-1:0] load_data_q, load_data_d;

  logic           req_misaligned;
  logic [3:0]     req_strb;
  logic [DPW-1:0] rdata_shifted;
  logic [DPW-1:0] rdata_ext;
  logic           timeout_hit;

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    req_strb = 4'b1111;
    case (req_size)
      2'b00:   req_strb = 4'b0001 << req_addr[1:0];
      2'b01:   req_strb = 4'b0011 << req_addr[1:0];
      default: req_strb = 4'b1111;
    endcase
  end

  // Right-align the addressed lane, then extend from the access width.
  always_comb begin
    rdata_shifted = mem_rdata >> {off_q, 3'b000};
    rdata_ext     = rdata_shifted;
    case (size_q)
      2'b00:   rdata_ext = {{(DPW-8){~uns_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   rdata_ext = {{(DPW-16){~uns_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CW'(TimeoutCycles - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
            addr_d  = {req_addr[DPW-1:2], 2'b00};
            we_d    = req_we;
            wstrb_d = req_strb;
            wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            off_d   = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
          end
        end
      end
      ST_REQ: begin
        // A completing handshake on the last allowed cycle wins over the timeout.
        if (mem_ready && we_q) begin
          state_d = ST_DONE;
        end else if (mem_ready && mem_rvalid) begin
          state_d     = ST_DONE;
          load_data_d = rdata_ext;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          timeout_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (mem_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d     = ST_DONE;
          load_data_d = rdata_ext;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          timeout_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
      load_data_q <= load_data_d;
    end
  end

  assign done      = (state_q == ST_DONE);
  assign stall     = req_valid & ~done;
  assign misalign  = misalign_q;
  assign timeout   = timeout_q;
  assign load_data = load_data_q;
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed checks of load_store_unit: stores, loads,
// misalignment, backpressure, timeout and reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misalign, timeout;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TimeoutCycles(15), .DPW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .load_data(load_data),
    .misalign(misalign), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // Store byte at lane 3
    set_req(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB);
    mem_ready = 1'b1;
    #1;
    chk("sb_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("sb_mem_req", {31'd0, mem_req}, 32'd1);
    chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sb_mem_addr", mem_addr, 32'h0000_0010);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    chk("sb_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_misalign", {31'd0, misalign}, 32'd0);
    chk("sb_stall_done", {31'd0, stall}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk("sb_done_pulse", {31'd0, done}, 32'd0);

    // Signed half load at lane 2, rvalid one cycle after handshake
    set_req(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0);
    tick();
    chk("lh_mem_req", {31'd0, mem_req}, 32'd1);
    chk("lh_mem_addr", mem_addr, 32'h0000_0020);
    tick();
    chk("lh_wait_req", {31'd0, mem_req}, 32'd0);
    chk("lh_wait_done", {31'd0, done}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
    tick();
    chk("lh_done", {31'd0, done}, 32'd1);
    chk("lh_data", load_data, 32'hFFFF_8001);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Unsigned half load, rvalid together with the handshake
    set_req(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
    tick();
    chk("lhu_done", {31'd0, done}, 32'd1);
    chk("lhu_data", load_data, 32'h0000_8001);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Signed byte load at lane 1
    set_req(1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_F678;
    tick();
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_data", load_data, 32'hFFFF_FFF6);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Misaligned word
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    tick();
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mis_load_data", load_data, 32'hFFFF_FFF6);
    req_valid = 1'b0;
    tick();
    chk("mis_pulse", {31'd0, misalign}, 32'd0);

    // Illegal size
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    tick();
    chk("ill_misalign", {31'd0, misalign}, 32'd1);
    req_valid = 1'b0;
    tick();

    // Backpressure: word store, ready low for 5 cycles
    set_req(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_ready = 1'b1;
      chk("bp_mem_req", {31'd0, mem_req}, 32'd1);
      chk("bp_mem_addr", mem_addr, 32'h0000_0008);
      chk("bp_wstrb", {28'd0, mem_wstrb}, 32'hF);
      chk("bp_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("bp_stall", {31'd0, stall}, 32'd1);
      chk("bp_done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("bp_final_done", {31'd0, done}, 32'd1);
    req_valid = 1'b0;
    tick();

    // Timeout: load accepted but no read data ever
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    mem_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n, 32'd16);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_load_data", load_data, 32'd0);
    chk("to_mem_req", {31'd0, mem_req}, 32'd0);
    req_valid = 1'b0;
    tick();

    // Reset while waiting for read data, then a normal load
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    tick();
    tick();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("rw_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rw_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rw_restart_req", {31'd0, mem_req}, 32'd1);
    chk("rw_restart_addr", mem_addr, 32'h0000_000C);
    tick();
    chk("rw_restart_done", {31'd0, done}, 32'd1);
    chk("rw_restart_data", load_data, 32'h1234_5678);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
